// File: rtl/car_sensor_cond_if.sv
// Car-loop conditioner bus: raw detector input plus conditioned request,
// presence, arrival strobe and arrival count.
// slave  = the conditioner itself, master = whoever drives the raw loop and
// consumes the conditioned outputs.
interface car_sensor_cond_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             x;
    logic             present;
    logic             arrive_pulse;
    logic [CNT_W-1:0] count;

    modport master (
        output sensor_raw,
        input  x,
        input  present,
        input  arrive_pulse,
        input  count
    );

    modport slave (
        input  sensor_raw,
        output x,
        output present,
        output arrive_pulse,
        output count
    );
endinterface

// File: rtl/car_sensor_cond.sv
// car_sensor_cond: turns the raw roadside loop detector into the clean request
// `x` for the highway/country-road light controller.
// Synchroniser -> debounce -> IDLE/REQ/HOLD request FSM with a grace period.
// Optional macro CAR_SENSOR_COUNT_EN builds a saturating arrival counter;
// without it `count` is tied to zero but the port remains.
module car_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst,
    car_sensor_cond_if.slave  bus
);
    // A zero-length hold still needs a legal one-bit counter.
    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HCNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [1:0]        r_sync;
    logic              w_s;
    logic              r_present;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_arrive;
    state_t            r_state;
    state_t            w_state_next;
    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_next;
    logic [CNT_W-1:0]  r_count;

    assign w_s = r_sync[1];

    // Two-flop synchroniser for the asynchronous loop signal.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], bus.sensor_raw};
        end
    end

    // Debounce: present only follows s after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; the arrival strobe fires on the 0->1 change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_present <= 1'b0;
            r_dcnt    <= '0;
            r_arrive  <= 1'b0;
        end else begin
            r_arrive <= 1'b0;
            if (w_s == r_present) begin
                r_dcnt <= '0;
            end else if (r_dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_present <= w_s;
                r_dcnt    <= '0;
                r_arrive  <= w_s;
            end else begin
                r_dcnt <= r_dcnt + DCNT_W'(1);
            end
        end
    end

    // Request FSM state and grace counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hcnt  <= w_hcnt_next;
        end
    end

    // Request FSM next state: a returning car in HOLD always wins over expiry,
    // so x never glitches low on re-arrival.
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        case (r_state)
            ST_IDLE: begin
                if (r_present) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!r_present) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_HOLD;
                        w_hcnt_next  = HCNT_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (r_present) begin
                    w_state_next = ST_REQ;
                end else if (r_hcnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_hcnt_next = r_hcnt - HCNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef CAR_SENSOR_COUNT_EN
    // Saturating arrival counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_arrive && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end
`else
    assign r_count = '0;
`endif

    // x is decoded from the state flops alone so it is glitch-free.
    assign bus.x            = (r_state != ST_IDLE);
    assign bus.present      = r_present;
    assign bus.arrive_pulse = r_arrive;
    assign bus.count        = r_count;

endmodule

// File: tb/tb_car_sensor_cond.sv
// Bench for car_sensor_cond (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, CNT_W=2).
// A per-cycle vector table covers reset, arrival and departure; hand-written
// sequences cover glitch rejection, re-arrival in HOLD, mid-run reset and the
// arrival counter (expectation follows CAR_SENSOR_COUNT_EN).
module tb_car_sensor_cond;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic rst;
        logic raw;
        logic x;
        logic present;
        logic arrive;
    } vec_t;

    vec_t vecs[$];

    car_sensor_cond_if #(.CNT_W(2)) u_if ();

    car_sensor_cond #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8),
        .CNT_W(2)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic raw);
        @(negedge clk);
        rst = r;
        u_if.sensor_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic push(input int n, input logic r, input logic raw,
                        input logic ex, input logic ep, input logic ea);
        vec_t v;
        v.rst = r; v.raw = raw; v.x = ex; v.present = ep; v.arrive = ea;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        int exp_cnt;
        int pulses;
        bit seen;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        u_if.sensor_raw = 1'b0;

        // rows: rst, raw, x, present, arrive_pulse (values after that edge)
        push(3, 1, 1, 0, 0, 0);   // reset held with raw high
        push(5, 0, 1, 0, 0, 0);   // edges 1..5 after release: still debouncing
        push(1, 0, 1, 0, 1, 1);   // edge 6: present rises, one-cycle strobe
        push(3, 0, 1, 1, 1, 0);   // x follows one edge later
        push(5, 0, 0, 1, 1, 0);   // raw drops; present holds for 5 edges
        push(9, 0, 0, 1, 0, 0);   // present falls (f); x held through f+8
        push(2, 0, 0, 0, 0, 0);   // x low after f+9

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].raw);
            chk("tbl_x", i, u_if.x, vecs[i].x);
            chk("tbl_present", i, u_if.present, vecs[i].present);
            chk("tbl_arrive", i, u_if.arrive_pulse, vecs[i].arrive);
            if (vecs[i].rst) chk("tbl_rst_count", i, u_if.count, 0);
            $display("vec %0d rst=%0d raw=%0d -> x=%0d present=%0d arrive=%0d",
                     i, vecs[i].rst, vecs[i].raw, u_if.x, u_if.present, u_if.arrive_pulse);
        end

        // Glitch: three raw-high cycles must never reach present.
        for (int k = 0; k < 15; k++) begin
            step(1'b0, (k < 3) ? 1'b1 : 1'b0);
            chk("glitch_present", k, u_if.present, 0);
            chk("glitch_x", k, u_if.x, 0);
            chk("glitch_arrive", k, u_if.arrive_pulse, 0);
        end
        $display("glitch sequence done");

        // Bring a car in and wait (bounded) for the request.
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, 1'b1);
            seen = u_if.x;
        end
        chk("arrive_timeout", 0, seen, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Re-arrival: raw low 5 cycles then back; present falls at k=5,
        // returns at k=10 while the hold counter is at 3; x never drops.
        for (int k = 0; k < 21; k++) begin
            step(1'b0, (k < 5) ? 1'b0 : 1'b1);
            chk("rearr_x", k, u_if.x, 1);
            chk("rearr_present", k, u_if.present, (k >= 5 && k < 10) ? 0 : 1);
            chk("rearr_arrive", k, u_if.arrive_pulse, (k == 10) ? 1 : 0);
        end
        $display("re-arrival sequence done");

        // Mid-run reset aborts everything on the next edge.
        step(1'b1, 1'b1);
        chk("midrst_x", 0, u_if.x, 0);
        chk("midrst_present", 0, u_if.present, 0);
        chk("midrst_arrive", 0, u_if.arrive_pulse, 0);
        chk("midrst_count", 0, u_if.count, 0);
        step(1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            chk("postrst_present", k, u_if.present, 0);
            chk("postrst_x", k, u_if.x, 0);
        end
        $display("mid-run reset done");

        // Counter: five arrivals, CNT_W=2 saturates at 3.
        for (int a = 1; a <= 5; a++) begin
            pulses = 0;
            for (int k = 0; k < 16; k++) begin
                step(1'b0, (k < 8) ? 1'b1 : 1'b0);
                if (u_if.arrive_pulse) pulses++;
            end
`ifdef CAR_SENSOR_COUNT_EN
            exp_cnt = (a < 3) ? a : 3;
`else
            exp_cnt = 0;
`endif
            chk("cnt_pulses", a, pulses, 1);
            chk("count", a, u_if.count, exp_cnt);
            $display("arrival %0d: pulses=%0d count=%0d", a, pulses, u_if.count);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
